// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared widths and state encoding for the ALU iterative
//                shift sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_W     = 5;
    localparam int ALU_AMT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_seq_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_shl1_step.sv
`default_nettype none
// ============================================================================
//  Module      : alu_shl1_step
//  Description : Combinational one-bit shift-left / rotate-left step.
//                out_bit is the MSB leaving the word; the LSB is zero
//                filled for a shift or takes the old MSB for a rotate.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_shl1_step #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] r,
    input  logic             rot,
    output logic [WIDTH-1:0] r_next,
    output logic             out_bit
);

    assign out_bit = r[WIDTH-1];
    assign r_next  = {r[WIDTH-2:0], rot & r[WIDTH-1]};

endmodule : alu_shl1_step
`default_nettype wire

// File: rtl/alu_shift_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_shift_seq
//  Description : Iterative shift-left controller, one bit per cycle, with a
//                valid/ready request and response handshake. Result and
//                carry match the combinational SHL (R = A<<n truncated,
//                CF = last bit shifted out, 0 when n = 0).
//                Optional macro ALU_SHIFT_SEQ_ROTATE_EN adds a req_rot input
//                selecting rotate-left instead of shift-left.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_shift_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int AMT_W = ALU_AMT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
`ifdef ALU_SHIFT_SEQ_ROTATE_EN
    input  logic             req_rot,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_cf,
    output logic             busy
);

    shift_seq_state_t state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             cf_q, cf_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;

    logic             w_accept;
    logic [AMT_W-1:0] w_amt;
    logic [WIDTH-1:0] w_step_r;
    logic             w_step_bit;
    logic             w_step_rot;

    // Only the low AMT_W bits of operand B carry the shift amount.
    logic unused_b_hi;
    assign unused_b_hi = ^req_b[WIDTH-1:AMT_W];
    assign w_amt       = req_b[AMT_W-1:0];
    assign w_accept    = req_valid & req_ready;

`ifdef ALU_SHIFT_SEQ_ROTATE_EN
    logic rot_q, rot_d;
    assign w_step_rot = rot_q;
`else
    assign w_step_rot = 1'b0;
`endif

    alu_shl1_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r       (r_q),
        .rot     (w_step_rot),
        .r_next  (w_step_r),
        .out_bit (w_step_bit)
    );

    assign rsp_r  = r_q;
    assign rsp_cf = cf_q;

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            cf_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef ALU_SHIFT_SEQ_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cf_q    <= cf_d;
            cnt_q   <= cnt_d;
`ifdef ALU_SHIFT_SEQ_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        cf_d      = cf_q;
        cnt_d     = cnt_q;
`ifdef ALU_SHIFT_SEQ_ROTATE_EN
        rot_d     = rot_q;
`endif
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
            end
            SHIFT: begin
                busy = 1'b1;
                r_d  = w_step_r;
                cf_d = w_step_bit;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (cnt_q <= AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                // A consumed response frees the slot for a new request in
                // the same cycle, giving zero-bubble back-to-back ops.
                req_ready = rsp_ready;
                if (rsp_ready && !req_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept only happens in IDLE or DONE, so it never races a SHIFT step.
        if (w_accept) begin
            r_d     = req_a;
            cf_d    = 1'b0;
            cnt_d   = w_amt;
`ifdef ALU_SHIFT_SEQ_ROTATE_EN
            rot_d   = req_rot;
`endif
            state_d = (w_amt != '0) ? SHIFT : DONE;
        end
    end

endmodule : alu_shift_seq
`default_nettype wire

// File: tb/tb_alu_shift_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_shift_seq
//  Description : Scoreboard bench for alu_shift_seq. The driver pushes the
//                expected response at each accept; an independent monitor
//                pops and compares on each response handshake and checks
//                accept-to-valid latency. Rotate vectors run when
//                ALU_SHIFT_SEQ_ROTATE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_shift_seq;
    import alu_pkg::*;

    localparam int W  = ALU_W;
    localparam int AW = ALU_AMT_W;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_rot   = 1'b0;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] req_a     = '0;
    logic [W-1:0] req_b     = '0;
    logic         req_ready;
    logic         rsp_valid;
    logic         rsp_cf;
    logic         busy;
    logic [W-1:0] rsp_r;

    alu_shift_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
`ifdef ALU_SHIFT_SEQ_ROTATE_EN
        .req_rot   (req_rot),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_r     (rsp_r),
        .rsp_cf    (rsp_cf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [W-1:0] r;
        logic         cf;
        logic [31:0]  acc;
        logic [31:0]  n;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    bit   head_seen = 1'b0;
    int   last_rsp_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: latency on first sight of rsp_valid, data on handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                if (!head_seen) begin
                    check("latency", 32'(cyc) - sbq[0].acc, sbq[0].n + 32'd1);
                    head_seen = 1'b1;
                end
                if (rsp_ready) begin
                    check("rsp_r", 32'(rsp_r), 32'(sbq[0].r));
                    check("rsp_cf", 32'(rsp_cf), 32'(sbq[0].cf));
                    void'(sbq.pop_front());
                    head_seen    = 1'b0;
                    last_rsp_cyc = cyc;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic rot,
                        input logic [W-1:0] er, input logic ecf, output int acc);
        int t;
        req_a = a; req_b = b; req_rot = rot; req_valid = 1'b1;
        acc = -1;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            acc = cyc;
            sbq.push_back('{er, ecf, 32'(cyc), 32'(b[AW-1:0])});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        // Operands must be ignored after the accept.
        req_a = W'($urandom);
        req_b = W'($urandom);
    endtask

    initial begin
        int acc1, acc2, t;
        logic [12:0] x;
        logic [W-1:0] b;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_r", 32'(rsp_r), 32'd0);
        check("rst_rsp_cf", 32'(rsp_cf), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;

        // Directed vectors
        send(5'b10110, 5'd1, 1'b0, 5'b01100, 1'b1, acc1);
        send(5'b10110, 5'd0, 1'b0, 5'b10110, 1'b0, acc1);
        send(5'b01011, 5'd5, 1'b0, 5'b00000, 1'b1, acc1);
        send(5'b11111, 5'd6, 1'b0, 5'b00000, 1'b0, acc1);
        send(5'b11111, 5'd7, 1'b0, 5'b00000, 1'b0, acc1);
        send(5'b01011, 5'b11010, 1'b0, 5'b01100, 1'b1, acc1);

        // Back-to-back, zero bubble
        send(5'b00011, 5'd2, 1'b0, 5'b01100, 1'b0, acc1);
        send(5'b10000, 5'd1, 1'b0, 5'b00000, 1'b1, acc2);
        check("zero_bubble", 32'(acc2), 32'(last_rsp_cyc));

        // Hold: rsp_ready low with a pending request
        t = 0;
        while (sbq.size() != 0 && t < 50) begin @(posedge clk); t++; end
        #1;
        rsp_ready = 1'b0;
        send(5'b10110, 5'd1, 1'b0, 5'b01100, 1'b1, acc1);
        req_a = 5'b00011; req_b = 5'd2; req_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
        for (int i = 0; i < 5; i++) begin
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_r", 32'(rsp_r), 32'b01100);
            check("hold_rsp_cf", 32'(rsp_cf), 32'd1);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send(5'b00011, 5'd2, 1'b0, 5'b01100, 1'b0, acc1);

        // Reset mid-operation
        send(5'b11111, 5'd7, 1'b0, 5'b00000, 1'b0, acc1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        sbq.delete();
        head_seen = 1'b0;
        @(negedge clk);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rsp_r", 32'(rsp_r), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(5'b10110, 5'd1, 1'b0, 5'b01100, 1'b1, acc1);

`ifdef ALU_SHIFT_SEQ_ROTATE_EN
        send(5'b10110, 5'd2, 1'b1, 5'b11010, 1'b0, acc1);
        send(5'b10110, 5'd1, 1'b1, 5'b01101, 1'b1, acc1);
`endif

        // All operand/amount pairs against a wide-shift model
        for (int a = 0; a < 32; a++) begin
            for (int n = 0; n < 8; n++) begin
                x = 13'(a) << n;
                b = W'($urandom);
                b[AW-1:0] = AW'(n);
                send(W'(a), b, 1'b0, x[W-1:0], x[W], acc1);
            end
        end

        // Drain
        t = 0;
        while (sbq.size() != 0 && t < 200) begin @(posedge clk); t++; end
        check("drain", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_shift_seq
`default_nettype wire
